// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse interface: receiver state encoding,
// receive error codes and the command/response bytes used by master and transmitter.
package mouse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DONE
    } rxState_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam logic [7:0] CMD_RESET         = 8'hFF;
    localparam logic [7:0] RSP_ACK           = 8'hFA;
    localparam logic [7:0] RSP_SELF_TEST_OK  = 8'hAA;
    localparam logic [7:0] RSP_DEVICE_ID     = 8'h00;
    localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic oddParity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the asynchronous PS/2 clock and data pads into the system clock
// domain and flags each falling edge of the PS/2 clock with a one-cycle pulse.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2Clk_i,
    input  logic ps2Data_i,
    output logic data_o,
    output logic fe_o
);

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   clkPrev_q;

    // Idle PS/2 lines are high, so resetting to ones avoids a false edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkSync_q  <= '1;
            dataSync_q <= '1;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= (clkSync_q << 1) | SYNC_STAGES'(ps2Clk_i);
            dataSync_q <= (dataSync_q << 1) | SYNC_STAGES'(ps2Data_i);
            clkPrev_q  <= clkSync_q[SYNC_STAGES-1];
        end
    end

    assign data_o = dataSync_q[SYNC_STAGES-1];
    assign fe_o   = clkPrev_q & ~clkSync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: deserialises start/8 data/odd parity/stop frames
// and hands each byte with its error code to the mouse master.
module mouse_receiver
    import mouse_pkg::*;
#(
    parameter int TIMEOUT     = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic dataSync;
    logic fe;

    rxState_e   state_q,    state_d;
    logic [7:0] shift_q,    shift_d;
    logic [2:0] bitCnt_q,   bitCnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0] pendErr_q,  pendErr_d;
    logic [7:0] byteRead_q, byteRead_d;
    logic [1:0] errCode_q,  errCode_d;
    logic       ready_q,    ready_d;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_syncEdge (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .ps2Clk_i (CLK_MOUSE_IN),
        .ps2Data_i(DATA_MOUSE_IN),
        .data_o   (dataSync),
        .fe_o     (fe)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bitCnt_q   <= 3'd0;
            tmo_q      <= '0;
            pendErr_q  <= ERR_NONE;
            byteRead_q <= 8'h00;
            errCode_q  <= ERR_NONE;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitCnt_q   <= bitCnt_d;
            tmo_q      <= tmo_d;
            pendErr_q  <= pendErr_d;
            byteRead_q <= byteRead_d;
            errCode_q  <= errCode_d;
            ready_q    <= ready_d;
        end
    end

    // Outputs are loaded on the stop-bit edge so BYTE_READY is high during DONE,
    // one cycle after that edge, with byte and code already valid.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        tmo_d      = '0;
        pendErr_d  = pendErr_q;
        byteRead_d = byteRead_q;
        errCode_d  = errCode_q;
        ready_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fe && !dataSync && READ_ENABLE) begin
                    state_d  = DATA;
                    bitCnt_d = 3'd0;
                end
            end

            DATA, PARITY, STOP: begin
                if (fe) begin
                    unique case (state_q)
                        DATA: begin
                            shift_d[bitCnt_q] = dataSync;
                            bitCnt_d          = bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                state_d = PARITY;
                            end
                        end
                        PARITY: begin
                            if (dataSync != oddParity(shift_q)) begin
                                pendErr_d = pendErr_q | ERR_PARITY;
                            end
                            state_d = STOP;
                        end
                        default: begin
                            byteRead_d = shift_q;
                            errCode_d  = pendErr_q | (dataSync ? ERR_NONE : ERR_STOP);
                            ready_d    = 1'b1;
                            pendErr_d  = ERR_NONE;
                            state_d    = DONE;
                        end
                    endcase
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    // Mouse stopped clocking mid-frame: drop everything collected so far.
                    state_d   = IDLE;
                    shift_d   = 8'h00;
                    bitCnt_d  = 3'd0;
                    pendErr_d = ERR_NONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            DONE: begin
                pendErr_d = ERR_NONE;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BYTE_READ       = byteRead_q;
    assign BYTE_ERROR_CODE = errCode_q;
    assign BYTE_READY      = ready_q;

endmodule
